// File: rtl/ntt_pkg.sv
// Shared constants for the q = 65537 NTT sequencers: transform size, widths and FSM encoding.
package ntt_pkg;

    localparam int unsigned Q       = 65537;
    localparam int unsigned LOG_N   = 6;
    localparam int unsigned N       = 1 << LOG_N;
    localparam int unsigned HALF_N  = N / 2;
    localparam int unsigned PSI_W   = LOG_N + 1;
    localparam int unsigned STAGE_W = 3;
    localparam int unsigned CNT_W   = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ntt_addr_gen.sv
// Cooley-Tukey butterfly addressing: (stage s, butterfly k) -> operand indices and twiddle ROM address.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [STAGE_W-1:0] s,
    input  logic [LOG_N-2:0]   k,
    output logic [LOG_N-1:0]   addr_a,
    output logic [LOG_N-1:0]   addr_b,
    output logic [PSI_W-1:0]   psi_addr
);

    localparam int unsigned AW = LOG_N;
    localparam int unsigned KW = LOG_N - 1;

    logic [AW-1:0] m;
    logic [AW-1:0] t;
    logic [KW-1:0] i;
    logic [KW-1:0] jo;
    logic [AW-1:0] base;

    // 2*i*t is a shift because 2*t = N >> s and i < m = 2^s
    always_comb begin
        m        = AW'(1) << s;
        t        = AW'(HALF_N) >> s;
        i        = k >> (STAGE_W'(KW) - s);
        jo       = k & KW'(t - AW'(1));
        base     = AW'(i) << (STAGE_W'(AW) - s);
        addr_a   = base | AW'(jo);
        addr_b   = addr_a + t;
        psi_addr = {m + AW'(i), 1'b0};
    end

endmodule

// File: rtl/ntt_controller.sv
// Forward NTT sequencer: issues one butterfly per handshake, throttles on outstanding
// writebacks and drains the datapath before every new stage.
module ntt_controller #(
    parameter int unsigned LOG_N           = ntt_pkg::LOG_N,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [LOG_N-1:0] cmd_addr_a,
    output logic [LOG_N-1:0] cmd_addr_b,
    output logic [LOG_N:0]   psi_addr,
    output logic [2:0]       cmd_stage,
    output logic             cmd_last,
    input  logic             bf_ack
);

    localparam int unsigned KW   = LOG_N - 1;
    localparam int unsigned SW   = ntt_pkg::STAGE_W;
    localparam int unsigned CW   = ntt_pkg::CNT_W;
    localparam int unsigned HALF = 1 << (LOG_N - 1);

    localparam logic [KW-1:0] K_LAST  = KW'(HALF - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(LOG_N - 1);
    localparam logic [CW-1:0] OUT_MAX = CW'(MAX_OUTSTANDING);

    ntt_pkg::state_t state;
    ntt_pkg::state_t state_nxt;
    logic [SW-1:0]   s;
    logic [SW-1:0]   s_nxt;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_nxt;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_nxt;
    logic            fire;
    logic            ack_eff;
    logic            issue_nxt;
    logic [LOG_N-1:0] gen_a;
    logic [LOG_N-1:0] gen_b;
    logic [LOG_N:0]   gen_psi;

    // Addresses are generated for the next (s, k) so the command outputs can be registered
    ntt_addr_gen u_addr_gen (
        .s        (s_nxt),
        .k        (k_nxt),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .psi_addr (gen_psi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ntt_pkg::ST_IDLE;
            s           <= '0;
            k           <= '0;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            s           <= s_nxt;
            k           <= k_nxt;
            outstanding <= out_nxt;
        end
    end

    // Next-state, stage/butterfly counters and outstanding tracking
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        out_nxt   = outstanding;
        fire      = cmd_valid & cmd_ready;
        ack_eff   = bf_ack && (outstanding != '0);

        if (fire && !ack_eff) begin
            out_nxt = outstanding + CW'(1);
        end else if (!fire && ack_eff) begin
            out_nxt = outstanding - CW'(1);
        end

        case (state)
            ntt_pkg::ST_IDLE: begin
                if (start) begin
                    state_nxt = ntt_pkg::ST_ISSUE;
                    s_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            ntt_pkg::ST_ISSUE: begin
                if (fire) begin
                    k_nxt = k + KW'(1);
                    if (k == K_LAST) begin
                        state_nxt = ntt_pkg::ST_DRAIN;
                    end
                end
            end
            ntt_pkg::ST_DRAIN: begin
                if (outstanding == '0) begin
                    if (s == S_LAST) begin
                        state_nxt = ntt_pkg::ST_DONE;
                    end else begin
                        state_nxt = ntt_pkg::ST_ISSUE;
                        s_nxt     = s + SW'(1);
                        k_nxt     = '0;
                    end
                end
            end
            ntt_pkg::ST_DONE: begin
                state_nxt = ntt_pkg::ST_IDLE;
                s_nxt     = '0;
                k_nxt     = '0;
            end
            default: begin
                state_nxt = ntt_pkg::ST_IDLE;
            end
        endcase

        issue_nxt = (state_nxt == ntt_pkg::ST_ISSUE);
    end

    // Registered command and status outputs; a stalled command holds because s, k and state hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_addr_a <= '0;
            cmd_addr_b <= '0;
            psi_addr   <= '0;
            cmd_stage  <= '0;
            cmd_last   <= 1'b0;
        end else begin
            busy       <= issue_nxt || (state_nxt == ntt_pkg::ST_DRAIN);
            done       <= (state_nxt == ntt_pkg::ST_DONE);
            cmd_valid  <= issue_nxt && (out_nxt < OUT_MAX);
            cmd_addr_a <= issue_nxt ? gen_a : '0;
            cmd_addr_b <= issue_nxt ? gen_b : '0;
            psi_addr   <= issue_nxt ? gen_psi : '0;
            cmd_stage  <= s_nxt;
            cmd_last   <= issue_nxt && (s_nxt == S_LAST) && (k_nxt == K_LAST);
        end
    end

endmodule

// File: doc/ntt_controller.md
Name: ntt_controller

Overview:
- Sequencer for the in-place, forward, Cooley-Tukey NTT over q = 65537, with N = 2^LOG_N coefficients.
- Walks stages and butterflies and issues one butterfly command per accepted handshake to the butterfly/memory datapath.
- Drives the 7-bit twiddle ROM address (psi_table).
- Throttles issue on outstanding butterflies and drains the pipeline at every stage boundary to avoid read-after-write hazards.

Parameters:
- LOG_N, 6: log2 of transform size; N = 64, 6 stages, N/2 = 32 butterflies per stage.
- MAX_OUTSTANDING, 8: maximum issued-but-unacknowledged butterflies, range 1..31.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a transform when idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final stage has fully drained
- cmd_valid  out  1  butterfly command valid
- cmd_ready  in  1  datapath accepts command
- cmd_addr_a  out  LOG_N  coefficient index j (upper input)
- cmd_addr_b  out  LOG_N  coefficient index j+t (lower input, multiplied by psi)
- psi_addr  out  LOG_N+1  twiddle ROM address = {m+i, 1'b0}
- cmd_stage  out  3  current stage s
- cmd_last  out  1  high on the final butterfly of the final stage
- bf_ack  in  1  one pulse per completed butterfly writeback

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; busy=0, done=0, cmd_valid=0, cmd_last=0; address outputs 0.
- States:
  - IDLE: start=1 -> ISSUE with s=0, k=0.
  - ISSUE: cmd_valid=1 when outstanding < MAX_OUTSTANDING, else 0. Fire = cmd_valid & cmd_ready. On fire, k increments. On fire with k = N/2-1 -> DRAIN.
  - DRAIN: cmd_valid=0; wait until outstanding = 0. Then if s = LOG_N-1 -> DONE, else s+1, k=0 -> ISSUE.
  - DONE: done=1 for one cycle -> IDLE. busy deasserts in the same cycle done pulses.
- start while busy: ignored.
- Address generation, combinational from registered s and k:
  - m = 1<<s, t = N>>(s+1)
  - i = k >> (LOG_N-1-s), jo = k & (t-1)
  - cmd_addr_a = 2*i*t + jo, cmd_addr_b = cmd_addr_a + t
  - psi_addr = (m+i)<<1; m+i < N, so the result fits in LOG_N+1 bits.
- Command stability: while cmd_valid=1 and cmd_ready=0, all cmd_* and psi_addr hold stable. cmd_valid never drops without a fire, except via reset.
- Outstanding counter (6 bits):
  - +1 on fire, -1 on bf_ack; simultaneous fire and bf_ack leaves it unchanged.
  - bf_ack with outstanding = 0 is ignored; the counter saturates at 0.
- Throughput: one butterfly per cycle when cmd_ready=1 and acks keep pace. Minimum latency = 6*32 issue cycles + per-stage drain + 1.
- Stage ordering: no command of stage s+1 is issued before all bf_ack pulses of stage s have been received.
- Reset mid-transform: everything returns to IDLE immediately; no done pulse. The datapath is reset by the same rst_n.

Decomposition:
- Shared package (ntt_pkg) holds:
  - Q = 65537, LOG_N, N
  - state encoding IDLE/ISSUE/DRAIN/DONE
  - the psi address formula width LOG_N+1
- One sub-module, ntt_addr_gen: purely combinational (s, k) -> (addr_a, addr_b, psi_addr). It is reused by the inverse-transform controller later.

Test Plan:
- start, cmd_ready=1, bf_ack one cycle after each fire -> first cmd s=0: addr_a=0, addr_b=32, psi_addr=2. Exactly 192 fires total; done pulses once; busy falls with done.
- Stage 1, k=16 -> addr_a=32, addr_b=48, psi_addr=6. Stage 5, k=31 -> addr_a=62, addr_b=63, psi_addr=126, cmd_last=1.
- Hold bf_ack=0 -> exactly 8 fires, then cmd_valid=0. One bf_ack pulse -> exactly one further fire.
- Random cmd_ready stalls -> outputs stable while valid & !ready. Scoreboard matches the golden (s, k) address sequence with no gaps or duplicates.
- Delay all stage-0 acks 20 cycles -> no stage-1 command before the 32nd stage-0 ack. The start pulse issued mid-run is ignored.
- Assert rst_n=0 at stage 3, k=10 -> next cycle busy=0, cmd_valid=0, no done. A new start restarts from s=0, addr_a=0.
